// File: rtl/snn_sched_pkg.sv
// Shared types and sizing helpers for the SNN timestep scheduler.
package snn_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INF_START,
        S_INF_WAIT,
        S_LRN_START,
        S_LRN_WAIT,
        S_DONE
    } state_t;

    localparam int INF_TIMEOUT_DEF = 4096;

    // Learner sweep: N y-updates, N*F weight RMWs, final write, return to idle.
    function automatic int learn_cycles(input int f, input int n);
        return n * (f + 1) + 2;
    endfunction

endpackage

// File: rtl/snn_cycle_timer.sv
// Loadable saturating down-counter with a zero flag; shared by the
// inference timeout and the fixed learner wait.
module snn_cycle_timer #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/snn_step_sched.sv
// Per-timestep sequencer: runs inference on each accepted spike vector and
// periodically launches a fixed-length STDP pass, never overlapping the two.
module snn_step_sched
    import snn_sched_pkg::*;
#(
    parameter int F           = 48,
    parameter int N           = 96,
    parameter int INF_TIMEOUT = INF_TIMEOUT_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic [F-1:0]     step_pre,
    output logic             inf_start,
    output logic [F-1:0]     inf_pre,
    input  logic             inf_done,
    input  logic [N-1:0]     inf_post,
    input  logic [7:0]       learn_every,
    output logic             lrn_enable,
    output logic [F-1:0]     lrn_pre,
    output logic [N-1:0]     lrn_post,
    output logic             step_done,
    output logic [CNT_W-1:0] step_count,
    output logic [CNT_W-1:0] learn_count,
    output logic             busy,
    output logic             err_timeout
);

    localparam int LEARN_CYCLES = learn_cycles(F, N);
    localparam int TMR_MAX      = (LEARN_CYCLES > INF_TIMEOUT) ? LEARN_CYCLES : INF_TIMEOUT;
    localparam int TMR_W        = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] INF_LOAD = TMR_W'(INF_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LRN_LOAD = TMR_W'(LEARN_CYCLES - 1);

    state_t             state_d, state_q;
    logic               ready_d, ready_q;
    logic [F-1:0]       inf_pre_d, inf_pre_q;
    logic [N-1:0]       lrn_post_d, lrn_post_q;
    logic [7:0]         phase_d, phase_q;
    logic [CNT_W-1:0]   step_cnt_d, step_cnt_q;
    logic [CNT_W-1:0]   learn_cnt_d, learn_cnt_q;
    logic               err_d, err_q;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]   tmr_val;
    logic               learn_go, timeout_now;

    snn_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        inf_pre_d   = inf_pre_q;
        lrn_post_d  = lrn_post_q;
        phase_d     = phase_q;
        step_cnt_d  = step_cnt_q;
        learn_cnt_d = learn_cnt_q;
        err_d       = err_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        tmr_val     = INF_LOAD;
        // >= so that lowering learn_every mid-run fires on the next step.
        learn_go    = (learn_every != 8'd0) && (phase_q >= (learn_every - 8'd1));
        timeout_now = (state_q == S_INF_WAIT) && tmr_zero && !inf_done;

        case (state_q)
            S_IDLE: begin
                if (step_valid && ready_q) begin
                    inf_pre_d = step_pre;
                    tmr_load  = 1'b1;
                    tmr_val   = INF_LOAD;
                    state_d   = S_INF_START;
                end
            end
            S_INF_START: begin
                state_d = S_INF_WAIT;
            end
            S_INF_WAIT: begin
                tmr_dec = 1'b1;
                if (inf_done) begin
                    lrn_post_d = inf_post;
                    if (learn_go) begin
                        // Timer is armed here so the learn window spans exactly LEARN_CYCLES from lrn_enable.
                        tmr_load = 1'b1;
                        tmr_val  = LRN_LOAD;
                        phase_d  = 8'd0;
                        state_d  = S_LRN_START;
                    end else begin
                        phase_d = phase_q + 8'd1;
                        state_d = S_DONE;
                    end
                end else if (tmr_zero) begin
                    err_d      = 1'b1;
                    lrn_post_d = '0;
                    phase_d    = phase_q + 8'd1;
                    state_d    = S_DONE;
                end
            end
            S_LRN_START: begin
                tmr_dec     = 1'b1;
                learn_cnt_d = learn_cnt_q + CNT_W'(1);
                state_d     = S_LRN_WAIT;
            end
            S_LRN_WAIT: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                step_cnt_d = step_cnt_q + CNT_W'(1);
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            inf_pre_q   <= '0;
            lrn_post_q  <= '0;
            phase_q     <= 8'd0;
            step_cnt_q  <= '0;
            learn_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            inf_pre_q   <= inf_pre_d;
            lrn_post_q  <= lrn_post_d;
            phase_q     <= phase_d;
            step_cnt_q  <= step_cnt_d;
            learn_cnt_q <= learn_cnt_d;
            err_q       <= err_d;
        end
    end

    assign step_ready  = ready_q;
    assign inf_start   = (state_q == S_INF_START);
    assign inf_pre     = inf_pre_q;
    assign lrn_enable  = (state_q == S_LRN_START);
    assign lrn_pre     = inf_pre_q;
    assign lrn_post    = lrn_post_q;
    assign step_done   = (state_q == S_DONE);
    assign step_count  = step_cnt_q;
    assign learn_count = learn_cnt_q;
    assign busy        = (state_q != S_IDLE);
    // The timeout decision shows in its own cycle; the sticky flag holds it afterwards.
    assign err_timeout = err_q | timeout_now;

endmodule

// File: tb/tb_snn_step_sched.sv
// Directed bench for snn_step_sched at F=4, N=3, INF_TIMEOUT=16 (LEARN_CYCLES=17).
module tb_snn_step_sched;

    localparam int F = 4;
    localparam int N = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          step_valid = 1'b0;
    logic          step_ready;
    logic [F-1:0]  step_pre = '0;
    logic          inf_start;
    logic [F-1:0]  inf_pre;
    logic          inf_done = 1'b0;
    logic [N-1:0]  inf_post = '0;
    logic [7:0]    learn_every = 8'd0;
    logic          lrn_enable;
    logic [F-1:0]  lrn_pre;
    logic [N-1:0]  lrn_post;
    logic          step_done;
    logic [31:0]   step_count;
    logic [31:0]   learn_count;
    logic          busy;
    logic          err_timeout;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int exp_steps  = 0;
    int exp_learns = 0;

    snn_step_sched #(.F(F), .N(N), .INF_TIMEOUT(16), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_valid  (step_valid),
        .step_ready  (step_ready),
        .step_pre    (step_pre),
        .inf_start   (inf_start),
        .inf_pre     (inf_pre),
        .inf_done    (inf_done),
        .inf_post    (inf_post),
        .learn_every (learn_every),
        .lrn_enable  (lrn_enable),
        .lrn_pre     (lrn_pre),
        .lrn_post    (lrn_post),
        .step_done   (step_done),
        .step_count  (step_count),
        .learn_count (learn_count),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drives one step from an idle/ready negedge; cycle 0 is the accept cycle.
    task automatic run_step(input logic [F-1:0] pre, input int done_at, input int early_at,
                            input logic [N-1:0] post, input logic hold, input int max_cyc,
                            output int t_acc, output int t_start, output int t_lrn,
                            output int t_err, output int t_done, output int t_ready,
                            output int n_lrn, output int n_done);
        t_acc = -1; t_start = -1; t_lrn = -1; t_err = -1; t_done = -1; t_ready = -1;
        n_lrn = 0; n_done = 0;
        step_pre   = pre;
        step_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= max_cyc; c++) begin
            #1;
            if (c == 1) t_acc = cyc;
            if (!hold) step_valid = 1'b0;
            inf_done = (c == done_at) || (c == early_at);
            inf_post = post;
            @(negedge clk);
            if (inf_start && t_start < 0) t_start = c;
            if (lrn_enable) begin n_lrn++; if (t_lrn < 0) t_lrn = c; end
            if (err_timeout && t_err < 0) t_err = c;
            if (step_done) begin n_done++; if (t_done < 0) t_done = c; end
            if (step_ready) begin t_ready = c; break; end
            @(posedge clk);
        end
        inf_done = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if ({inf_start, lrn_enable, step_done, busy, step_ready, err_timeout} !== 6'b0)
            $display("FAIL rst_ctrl: got %b expected 000000", {inf_start, lrn_enable, step_done, busy, step_ready, err_timeout}); else passed++;
        total++; if ({step_count, learn_count} !== 64'd0)
            $display("FAIL rst_counts: got %0d/%0d expected 0/0", step_count, learn_count); else passed++;
        total++; if ({inf_pre, lrn_pre, lrn_post} !== 11'd0)
            $display("FAIL rst_data: got %b expected 0", {inf_pre, lrn_pre, lrn_post}); else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (step_ready !== 1'b1) $display("FAIL rst_ready_after: got %b expected 1", step_ready); else passed++;
    endtask

    task automatic test_no_learn();
        int ta, ts, tl, te, td, tr, nl, nd;
        learn_every = 8'd0;
        run_step(4'b1010, 5, -1, 3'b011, 1'b0, 40, ta, ts, tl, te, td, tr, nl, nd);
        exp_steps++;
        total++; if (ts !== 1) $display("FAIL nl_inf_start: got %0d expected 1", ts); else passed++;
        total++; if (nl !== 0) $display("FAIL nl_lrn_enable: got %0d pulses expected 0", nl); else passed++;
        total++; if (td !== 6 || nd !== 1) $display("FAIL nl_step_done: got @%0d x%0d expected @6 x1", td, nd); else passed++;
        total++; if (tr !== 7) $display("FAIL nl_ready: got %0d expected 7", tr); else passed++;
        total++; if (inf_pre !== 4'b1010) $display("FAIL nl_inf_pre: got %b expected 1010", inf_pre); else passed++;
        total++; if (lrn_post !== 3'b011) $display("FAIL nl_lrn_post: got %b expected 011", lrn_post); else passed++;
        total++; if (step_count !== 32'(exp_steps) || learn_count !== 32'(exp_learns))
            $display("FAIL nl_counts: got %0d/%0d expected %0d/%0d", step_count, learn_count, exp_steps, exp_learns); else passed++;
    endtask

    task automatic test_learn_one();
        int ta, ts, tl, te, td, tr, nl, nd;
        learn_every = 8'd1;
        run_step(4'b1010, 5, -1, 3'b011, 1'b0, 60, ta, ts, tl, te, td, tr, nl, nd);
        exp_steps++; exp_learns++;
        total++; if (tl !== 6 || nl !== 1) $display("FAIL l1_lrn_enable: got @%0d x%0d expected @6 x1", tl, nl); else passed++;
        total++; if (td !== 23) $display("FAIL l1_step_done: got %0d expected 23", td); else passed++;
        total++; if (tr !== 24) $display("FAIL l1_ready: got %0d expected 24", tr); else passed++;
        total++; if (lrn_post !== 3'b011 || lrn_pre !== 4'b1010)
            $display("FAIL l1_lrn_data: got post=%b pre=%b expected 011/1010", lrn_post, lrn_pre); else passed++;
        total++; if (learn_count !== 32'(exp_learns)) $display("FAIL l1_learn_count: got %0d expected %0d", learn_count, exp_learns); else passed++;
    endtask

    task automatic test_learn_every3();
        int ta, ts, tl, te, td, tr, nl, nd;
        int exp_nl, exp_td;
        learn_every = 8'd3;
        for (int s = 1; s <= 6; s++) begin
            run_step(4'(s), 3, -1, 3'(s), 1'b0, 60, ta, ts, tl, te, td, tr, nl, nd);
            exp_nl = (s == 3 || s == 6) ? 1 : 0;
            exp_td = (exp_nl == 1) ? 21 : 4;
            exp_steps++; exp_learns += exp_nl;
            total++; if (nl !== exp_nl) $display("FAIL e3_lrn_step%0d: got %0d expected %0d", s, nl, exp_nl); else passed++;
            total++; if (td !== exp_td) $display("FAIL e3_done_step%0d: got %0d expected %0d", s, td, exp_td); else passed++;
        end
        total++; if (step_count !== 32'(exp_steps) || learn_count !== 32'(exp_learns))
            $display("FAIL e3_counts: got %0d/%0d expected %0d/%0d", step_count, learn_count, exp_steps, exp_learns); else passed++;
    endtask

    task automatic test_timeout();
        int ta, ts, tl, te, td, tr, nl, nd;
        learn_every = 8'd1;
        run_step(4'b0101, -1, -1, 3'b111, 1'b0, 40, ta, ts, tl, te, td, tr, nl, nd);
        exp_steps++;
        total++; if (te !== 17) $display("FAIL to_err: got %0d expected 17", te); else passed++;
        total++; if (td !== 18) $display("FAIL to_step_done: got %0d expected 18", td); else passed++;
        total++; if (nl !== 0) $display("FAIL to_lrn_enable: got %0d pulses expected 0", nl); else passed++;
        total++; if (lrn_post !== 3'b000) $display("FAIL to_lrn_post: got %b expected 000", lrn_post); else passed++;
        learn_every = 8'd0;
        run_step(4'b0011, 2, -1, 3'b101, 1'b0, 40, ta, ts, tl, te, td, tr, nl, nd);
        exp_steps++;
        total++; if (err_timeout !== 1'b1) $display("FAIL to_err_sticky: got %b expected 1", err_timeout); else passed++;
        total++; if (td !== 3 || lrn_post !== 3'b101)
            $display("FAIL to_next_step: got done@%0d post=%b expected @3 101", td, lrn_post); else passed++;
    endtask

    task automatic test_early_done();
        int ta, ts, tl, te, td, tr, nl, nd;
        learn_every = 8'd0;
        run_step(4'b1100, 4, 1, 3'b010, 1'b0, 40, ta, ts, tl, te, td, tr, nl, nd);
        exp_steps++;
        total++; if (td !== 5 || nd !== 1) $display("FAIL ed_step_done: got @%0d x%0d expected @5 x1", td, nd); else passed++;
        total++; if (tr !== 6) $display("FAIL ed_ready: got %0d expected 6", tr); else passed++;
    endtask

    task automatic test_back_to_back();
        int ta0, ta1, ts, tl, te, td, tr0, tr1, nl, nd;
        learn_every = 8'd0;
        run_step(4'b0001, 2, -1, 3'b001, 1'b1, 40, ta0, ts, tl, te, td, tr0, nl, nd);
        run_step(4'b0010, 2, -1, 3'b100, 1'b1, 40, ta1, ts, tl, te, td, tr1, nl, nd);
        step_valid = 1'b0;
        exp_steps += 2;
        total++; if (tr0 !== 4 || tr1 !== 4) $display("FAIL b2b_ready: got %0d,%0d expected 4,4", tr0, tr1); else passed++;
        total++; if (ta1 - ta0 !== 4) $display("FAIL b2b_spacing: got %0d expected 4", ta1 - ta0); else passed++;
        total++; if (step_count !== 32'(exp_steps)) $display("FAIL b2b_count: got %0d expected %0d", step_count, exp_steps); else passed++;
    endtask

    task automatic test_reset_mid_learn();
        learn_every = 8'd1;
        step_pre    = 4'b0110;
        step_valid  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            #1;
            step_valid = 1'b0;
            inf_done   = (c == 5);
            inf_post   = 3'b101;
            if (c < 16) @(posedge clk);
        end
        inf_done = 1'b0;
        total++; if (busy !== 1'b1 || learn_count !== 32'(exp_learns + 1))
            $display("FAIL rm_pre_state: got busy=%b learns=%0d expected 1/%0d", busy, learn_count, exp_learns + 1); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if ({inf_start, lrn_enable, step_done, busy, step_ready, err_timeout} !== 6'b0)
            $display("FAIL rm_async_ctrl: got %b expected 000000", {inf_start, lrn_enable, step_done, busy, step_ready, err_timeout}); else passed++;
        total++; if ({step_count, learn_count} !== 64'd0 || {inf_pre, lrn_post} !== 7'd0)
            $display("FAIL rm_async_state: got %0d/%0d data=%b expected 0/0 0", step_count, learn_count, {inf_pre, lrn_post}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (step_ready !== 1'b1 || busy !== 1'b0 || step_done !== 1'b0)
            $display("FAIL rm_release: got ready=%b busy=%b done=%b expected 1/0/0", step_ready, busy, step_done); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_no_learn();
        test_learn_one();
        test_learn_every3();
        test_timeout();
        test_early_done();
        test_back_to_back();
        test_reset_mid_learn();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/snn_step_sched.md
# snn_step_sched

Per-timestep sequencer for the SNN core. It accepts one presynaptic spike vector per timestep and starts the inference core with it. It collects the postsynaptic spike vector and, on a programmable cadence, launches one STDP learning pass on the sequential Q14 learner, waiting out the learner's fixed RMW sweep before it releases the next timestep. It sits between the spike source/host and the inference core plus learner, which share the weight memory. It guarantees that inference and learning never overlap.

## Interface
Parameters:
- F, 48, presynaptic count
- N, 96, postsynaptic count
- INF_TIMEOUT, 4096, max cycles waiting for inf_done
- CNT_W, 32, width of step/learn counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- step_valid  in  1  upstream timestep available
- step_ready  out  1  scheduler can accept a timestep
- step_pre  in  F  presyn spikes for the step
- inf_start  out  1  one-cycle pulse: start inference
- inf_pre  out  F  latched presyn spikes, stable from inf_start until next accept
- inf_done  in  1  inference finished (single-cycle pulse)
- inf_post  in  N  postsyn spikes, sampled when inf_done=1
- learn_every  in  8  learn once per this many steps; 0 = never
- lrn_enable  out  1  one-cycle pulse to learner enable
- lrn_pre  out  F  = inf_pre
- lrn_post  out  N  latched postsyn spikes, stable through learning
- step_done  out  1  one-cycle pulse at end of step
- step_count  out  CNT_W  completed steps
- learn_count  out  CNT_W  learning passes launched
- busy  out  1  state != S_IDLE
- err_timeout  out  1  sticky: inference timed out

## Operation
- States: S_IDLE, S_INF_START, S_INF_WAIT, S_LRN_START, S_LRN_WAIT, S_DONE.
- S_IDLE: step_ready=1. On step_valid&&step_ready, latch step_pre into inf_pre and clear the cycle counter. Then go to S_INF_START.
- S_INF_START: inf_start=1 for this cycle only. Go to S_INF_WAIT. An inf_done seen in this cycle is ignored.
- S_INF_WAIT: the cycle counter increments each cycle.
  - On inf_done, latch inf_post into lrn_post and evaluate the learn decision.
  - If the counter reaches INF_TIMEOUT-1 without inf_done, set err_timeout, clear lrn_post, skip learning, and go to S_DONE.
- Learn decision: learn_every!=0 && phase>=learn_every-1. If true, go to S_LRN_START; otherwise go to S_DONE.
  - phase is an 8-bit counter. It is cleared when learning launches and incremented otherwise at S_DONE.
  - The >= comparison makes a mid-run decrease of learn_every fire on the next step rather than wait for wrap.
- S_LRN_START: lrn_enable=1 for one cycle, learn_count++, and load the timer with LEARN_CYCLES-1. Go to S_LRN_WAIT.
- S_LRN_WAIT: the timer counts down to 0, then go to S_DONE.
  - LEARN_CYCLES = N*(F+1)+2, which is 4706 at defaults.
  - This covers the learner's N y-updates, N*F weight RMWs, the registered final write and its return to idle. The learner has no done output, so the fixed count is authoritative.
- S_DONE: step_done=1 and step_count++. Go to S_IDLE.
- inf_pre, lrn_pre and lrn_post hold their values through S_IDLE. They change only on the next accept or on inf_done.
- Counters wrap modulo 2^CNT_W. err_timeout clears only on reset.

## Timing
- Reset values:
  - All outputs are 0, including inf_pre/lrn_post, both counters and err_timeout.
  - step_ready=0 during reset and 1 from the first cycle after release, since the state is S_IDLE.
  - phase=0.
- Let accept be cycle 0. Then inf_start is at cycle 1.
- Let inf_done be first sampled in S_INF_WAIT at cycle k≥2.
  - No learning: step_done at k+1, step_ready=1 at k+2.
  - Learning: lrn_enable at k+1, step_done at k+1+LEARN_CYCLES, step_ready=1 at k+2+LEARN_CYCLES.
- Timeout: err_timeout and the S_DONE transition are registered at cycle 1+INF_TIMEOUT. step_done follows on the next cycle.
- Back-to-back steps: with step_valid held high, one step is accepted every k+2 cycles (no learning).
- Reset asserted mid-step: the state returns to S_IDLE immediately and no pulse is emitted. The learner must be reset by the same rst_n.

## Structure
- snn_sched_pkg contains:
  - the state_t enum;
  - the function learn_cycles(F,N) returning N*(F+1)+2;
  - the INF_TIMEOUT default.
- One sub-module, snn_cycle_timer: a loadable down-counter with a zero flag. It is shared for the inference timeout (load INF_TIMEOUT-1) and the learn wait (load LEARN_CYCLES-1).

## Test plan
All scenarios use F=4, N=3 (LEARN_CYCLES=17) and INF_TIMEOUT=16.
- learn_every=0, pre=4'b1010, inf_done at cycle 5 with post=3'b011 -> inf_start@1, inf_pre=1010, lrn_enable never, step_done@6, step_count=1.
- learn_every=1, same stimulus -> lrn_enable@6, lrn_post=011, lrn_pre=1010, step_done@23, step_ready@24, learn_count=1.
- learn_every=3, 6 consecutive steps -> lrn_enable on steps 3 and 6 only, learn_count=2, step_count=6.
- inf_done never asserted -> err_timeout=1 @17, step_done@18, lrn_post=000, no lrn_enable; err_timeout remains set on a subsequent good step.
- inf_done pulsed in the inf_start cycle, then again at cycle 4 -> the first pulse is ignored and step_done@5.
- rst_n dropped at cycle 10 of S_LRN_WAIT -> all outputs 0 asynchronously, step_ready=1 after release, counters 0.
